// File: rtl/imem_program_loader_pkg.sv
// Shared instruction-field constants and loader state encoding.
package imem_program_loader_pkg;

  // Instruction field positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int F1_HI  = 26;
  localparam int F1_LO  = 18;
  localparam int F2_HI  = 17;
  localparam int F2_LO  = 9;
  localparam int F3_HI  = 8;
  localparam int F3_LO  = 0;

  // Defined opcodes
  localparam logic [4:0] OPC_NOP  = 5'b10000;
  localparam logic [4:0] OPC_LI   = 5'b00101;
  localparam logic [4:0] OPC_ADD  = 5'b00000;
  localparam logic [4:0] OPC_BEQ  = 5'b10101;
  localparam logic [4:0] OPC_JUMP = 5'b10010;
  localparam logic [4:0] OPC_IN   = 5'b10110;
  localparam logic [4:0] OPC_OUT  = 5'b10111;

  // Highest defined opcode; anything above it is rejected
  localparam logic [4:0] MAX_OPCODE = OPC_OUT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } load_state_t;

  // True when the opcode field of w does not exceed max_opc
  function automatic logic opcode_legal(input logic [31:0] w, input logic [4:0] max_opc);
    return w[OPC_HI:OPC_LO] <= max_opc;
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word assembler with opcode legality check.
// The first three bytes of a word live in a 24-bit shift register; the
// fourth byte is combined combinationally so the complete word and its
// legality are available in the same cycle as the final transfer.
module imem_word_assembler #(
  parameter logic [4:0] MAX_OPCODE = 5'b10111
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_complete,
  output logic        opcode_ok
);
  import imem_program_loader_pkg::*;

  logic [23:0] shreg;
  logic [1:0]  cnt;

  // Shift accepted bytes in MSB-first; counter wraps to 0 after the 4th byte
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= {shreg[15:0], byte_in};
      cnt   <= cnt + 2'd1;
    end
  end

  assign word          = {shreg, byte_in};
  assign word_complete = accept && (cnt == 2'd3);
  assign opcode_ok     = opcode_legal(word, MAX_OPCODE);

endmodule

// File: rtl/imem_program_loader.sv
// Byte-stream program loader for the 64 x 32-bit instruction memory.
// Stream format: one length byte N (1..DEPTH), then N big-endian words.
// The CPU is held while a load is in progress.
module imem_program_loader #(
  parameter int         DEPTH      = 64,
  parameter int         ADDR_WIDTH = 6,
  parameter logic [4:0] MAX_OPCODE = 5'b10111
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  import imem_program_loader_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  load_state_t           state, state_next;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   words_inc;
  logic                  xfer;
  logic                  len_bad;
  logic                  asm_accept;
  logic [31:0]           word;
  logic                  word_complete;
  logic                  opcode_ok;

  // A byte offered alongside load_start is dropped
  assign in_ready   = (state == ST_LEN) || (state == ST_DATA);
  assign xfer       = in_valid && in_ready && !load_start;
  assign asm_accept = xfer && (state == ST_DATA);
  assign len_bad    = (in_data == 8'd0) || (int'(in_data) > DEPTH);
  assign words_inc  = words_loaded + 1'b1;

  imem_word_assembler #(
    .MAX_OPCODE (MAX_OPCODE)
  ) u_asm (
    .clock         (clock),
    .reset         (reset),
    .clear         (load_start),
    .accept        (asm_accept),
    .byte_in       (in_data),
    .word          (word),
    .word_complete (word_complete),
    .opcode_ok     (opcode_ok)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state and state-decoded outputs; load_start overrides every state
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_LEN: begin
        cpu_hold = 1'b1;
        if (xfer) state_next = len_bad ? ST_ERROR : ST_DATA;
      end
      ST_DATA: begin
        cpu_hold = 1'b1;
        if (word_complete) state_next = opcode_ok ? ST_WRITE : ST_ERROR;
      end
      ST_WRITE: begin
        cpu_hold   = 1'b1;
        wr_en      = 1'b1;
        state_next = (words_inc == len_q) ? ST_DONE : ST_DATA;
      end
      ST_DONE:  done  = 1'b1;
      ST_ERROR: error = 1'b1;
      default:  state_next = ST_IDLE;
    endcase
    if (load_start) state_next = ST_LEN;
  end

  // Length latch, write address/data and word count; wr_data/wr_addr hold between writes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q        <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      words_loaded <= '0;
    end else if (load_start) begin
      wr_addr      <= '0;
      words_loaded <= '0;
    end else begin
      if (state == ST_LEN && xfer) len_q <= (ADDR_WIDTH+1)'(in_data);
      if (state == ST_DATA && word_complete && opcode_ok) wr_data <= word;
      if (state == ST_WRITE) begin
        words_loaded <= words_inc;
        // The last address stays put so a full-depth load never wraps to 0
        if (wr_addr != LAST_ADDR) wr_addr <= wr_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: vector table, directed
// multi-cycle sequences and randomized loads against a word-level model.
module tb_imem_program_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          load_start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  imem_program_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .MAX_OPCODE(5'b10111)) dut (
    .clock(clock), .reset(reset), .load_start(load_start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Monitors: every memory write and every byte transfer, sampled mid-cycle
  logic [AW+31:0] wq[$];
  int             xfers = 0;
  always @(negedge clock) begin
    if (!reset && wr_en) wq.push_back({wr_addr, wr_data});
    if (!reset && in_valid && in_ready && !load_start) xfers++;
  end

  logic [31:0] prog[DEPTH];
  int          wbase;
  int          xbase;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // All tasks start and end at posedge+1
  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clock); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap, output bit ok);
    int t = 0;
    ok = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clock); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clock);
      if (in_ready) ok = 1'b1;
      @(posedge clock); #1;
      if (ok || done || error || t > 20) break;
      t++;
    end
    in_valid = 1'b0;
  endtask

  // Drive a load of prog[0..] with length byte len, checking per-word timing
  task automatic run(input logic [7:0] len, input bit gap);
    bit ok;
    wbase = wq.size();
    xbase = xfers;
    pulse_start();
    send_byte(len, gap, ok);
    chk("len_xfer", ok, 1);
    if (len == 0 || int'(len) > DEPTH) begin
      chk("len_err_next_cycle", error, 1);
      chk("len_err_ready", in_ready, 0);
      return;
    end
    chk("hold_during_load", cpu_hold, 1);
    for (int i = 0; i < int'(len); i++) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(prog[i][31-8*b -: 8], gap, ok);
        chk("byte_xfer", ok, 1);
      end
      if (prog[i][31:27] > 5'd23) begin
        chk("bad_opc_err", error, 1);
        chk("bad_opc_no_wr", wr_en, 0);
        return;
      end
      chk("wr_en", wr_en, 1);
      chk("wr_addr", wr_addr, i);
      chk("wr_data", wr_data, prog[i]);
      chk("write_stall", in_ready, 0);
    end
    for (int t = 0; t < 10 && !(done || error); t++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic final_chk(input bit e_done, input bit e_err, input int e_nw);
    int n;
    n = wq.size() - wbase;
    chk("done", done, e_done);
    chk("error", error, e_err);
    chk("words_loaded", words_loaded, e_nw);
    chk("cpu_hold_end", cpu_hold, 0);
    chk("in_ready_end", in_ready, 0);
    chk("num_writes", n, e_nw);
    for (int k = 0; k < n && k < e_nw; k++)
      chk("write_rec", wq[wbase+k], {AW'(k), prog[k]});
  endtask

  typedef struct {
    logic [7:0]  len;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          gap;
    bit          e_done;
    bit          e_err;
    int          e_nw;
    int          e_xfers;
  } vec_t;

  vec_t vt[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit e_err;
    int e_nw;
    int len;

    vt[0] = '{8'h02, 32'h28040000, 32'h28080400, 1'b0, 1'b1, 1'b0, 2, 9};
    vt[1] = '{8'h00, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 0, 1};
    vt[2] = '{8'h41, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 0, 1};
    vt[3] = '{8'h01, 32'hC0000000, 32'h0,        1'b0, 1'b0, 1'b1, 0, 5};
    vt[4] = '{8'h01, 32'h90080000, 32'h0,        1'b1, 1'b1, 1'b0, 1, 5};
    vt[5] = '{8'h01, 32'hB8000000, 32'h0,        1'b0, 1'b1, 1'b0, 1, 5};
    vt[6] = '{8'h02, 32'h28040000, 32'hC0000000, 1'b0, 1'b0, 1'b1, 1, 9};

    reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clock);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words", words_loaded, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Vector table
    foreach (vt[v]) begin
      prog[0] = vt[v].w0;
      prog[1] = vt[v].w1;
      run(vt[v].len, vt[v].gap);
      final_chk(vt[v].e_done, vt[v].e_err, vt[v].e_nw);
      chk("xfer_count", xfers - xbase, vt[v].e_xfers);
    end

    // Bytes offered after DONE are refused
    prog[0] = 32'h28040000;
    run(8'h01, 1'b0);
    xbase = xfers;
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(posedge clock);
    #1; in_valid = 1'b0;
    chk("post_done_xfers", xfers - xbase, 0);
    chk("post_done_words", words_loaded, 1);
    chk("post_done_done", done, 1);

    // Restart mid-word: partial bytes are discarded
    wbase = wq.size();
    pulse_start();
    send_byte(8'h01, 1'b0, ok);
    send_byte(8'h28, 1'b0, ok);
    send_byte(8'h04, 1'b0, ok);
    pulse_start();
    chk("restart_in_len", in_ready, 1);
    chk("restart_words", words_loaded, 0);
    prog[0] = 32'h80000000;
    run(8'h01, 1'b0);
    final_chk(1'b1, 1'b0, 1);

    // load_start with a concurrent zero length byte: byte is dropped
    pulse_start();
    load_start = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    @(posedge clock); #1;
    load_start = 1'b0; in_valid = 1'b0;
    chk("simul_no_err", error, 0);
    chk("simul_still_len", in_ready, 1);
    wbase = wq.size();
    send_byte(8'h01, 1'b0, ok);
    for (int b = 0; b < 4; b++) send_byte(prog[0][31-8*b -: 8], 1'b0, ok);
    @(posedge clock); #1;
    final_chk(1'b1, 1'b0, 1);

    // Asynchronous reset in the middle of DATA
    pulse_start();
    send_byte(8'h02, 1'b0, ok);
    send_byte(8'h28, 1'b0, ok);
    send_byte(8'h04, 1'b0, ok);
    #2 reset = 1'b1;
    #1;
    chk("arst_cpu_hold", cpu_hold, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_wr_data", wr_data, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_words", words_loaded, 0);
    chk("arst_done_err", {done, error, wr_en}, 0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    wbase = wq.size(); xbase = xfers;
    in_valid = 1'b1; in_data = 8'h00;
    repeat (6) @(posedge clock);
    #1; in_valid = 1'b0;
    chk("arst_ignore_xfers", xfers - xbase, 0);
    chk("arst_ignore_writes", wq.size() - wbase, 0);
    chk("arst_idle_hold", cpu_hold, 0);

    // Randomized loads against a word-level model
    for (int it = 0; it < 25; it++) begin
      int r;
      bit allow_bad;
      r = $urandom_range(0, 9);
      allow_bad = (it != 0);
      if (it == 0)     len = DEPTH;
      else if (r == 0) len = 0;
      else if (r == 1) len = $urandom_range(DEPTH + 1, 255);
      else             len = $urandom_range(1, 8);
      for (int i = 0; i < DEPTH; i++) begin
        logic [4:0] opc;
        if (allow_bad && $urandom_range(0, 7) == 0) opc = 5'($urandom_range(24, 31));
        else                                       opc = 5'($urandom_range(0, 23));
        prog[i] = {opc, 27'($urandom)};
      end
      // Model: bad length -> error with no writes; otherwise words are
      // written in order until the first illegal opcode
      e_err = 1'b0;
      e_nw  = 0;
      if (len == 0 || len > DEPTH) e_err = 1'b1;
      else begin
        for (int i = 0; i < len && !e_err; i++) begin
          if (prog[i][31:27] > 5'd23) e_err = 1'b1;
          else e_nw++;
        end
      end
      run(8'(len), bit'($urandom_range(0, 1)));
      final_chk(!e_err, e_err, e_nw);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
